// File: rtl/sin_seq_pkg.sv
// Shared state encoding and quadrant constants for the quarter-wave sin sequencer.
// Build option: SIN_SEQ_COS_EN adds the cos read/capture states.
package sin_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
`ifdef SIN_SEQ_COS_EN
    ST_OUT  = 3'd3,
    ST_RDC  = 3'd4,
    ST_CAPC = 3'd5
`else
    ST_OUT  = 3'd3
`endif
  } seq_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int                           PHASE_WIDTH_DEF = 16;
  localparam logic [PHASE_WIDTH_DEF-1:0] QUARTER_STEP    = 16'h4000;

  // Width-generic quarter-turn step: 2**(pw-2) as a 32-bit value.
  function automatic logic [31:0] quarter_step(input int pw);
    return 32'd1 << (pw - 2);
  endfunction

endpackage

// File: rtl/sin_table_seq_if.sv
// ROM request/response bus plus the output sample stream of the sin sequencer.
// Build option: SIN_SEQ_COS_EN adds cos_data.
interface sin_table_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADR_WIDTH  = 8
);
  logic                  tbl_rd;
  logic [ADR_WIDTH-1:0]  tbl_addr;
  logic [DATA_WIDTH-1:0] tbl_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH:0]   out_data;
`ifdef SIN_SEQ_COS_EN
  logic [DATA_WIDTH:0]   cos_data;
`endif

  modport master (
    output tbl_rd,
    output tbl_addr,
    input  tbl_dout,
    output out_valid,
    input  out_ready,
`ifdef SIN_SEQ_COS_EN
    output cos_data,
`endif
    output out_data
  );

  modport slave (
    input  tbl_rd,
    input  tbl_addr,
    output tbl_dout,
    input  out_valid,
    output out_ready,
`ifdef SIN_SEQ_COS_EN
    input  cos_data,
`endif
    input  out_data
  );
endinterface

// File: rtl/sin_quadrant_fold.sv
// Folds a full-turn phase into a quarter-wave ROM address and a negate flag.
// Only the top ADR_WIDTH+2 phase bits matter; the rest are fractional.
module sin_quadrant_fold
  import sin_seq_pkg::*;
#(
  parameter int PHASE_WIDTH = 16,
  parameter int ADR_WIDTH   = 8
) (
  input  logic [PHASE_WIDTH-1:0] phase,
  output logic [ADR_WIDTH-1:0]   addr,
  output logic                   neg
);
  logic [1:0]           quad_s;
  logic [ADR_WIDTH-1:0] idx_s;
  logic                 unused_s;

  assign quad_s   = phase[PHASE_WIDTH-1 -: 2];
  assign idx_s    = phase[PHASE_WIDTH-3 -: ADR_WIDTH];
  assign unused_s = ^phase;

  // Odd quadrants walk the table backwards; upper half-turn is negative.
  always_comb begin
    addr = idx_s;
    neg  = 1'b0;
    case (quad_s)
      Q0: begin
        addr = idx_s;
        neg  = 1'b0;
      end
      Q1: begin
        addr = {ADR_WIDTH{1'b1}} - idx_s;
        neg  = 1'b0;
      end
      Q2: begin
        addr = idx_s;
        neg  = 1'b1;
      end
      Q3: begin
        addr = {ADR_WIDTH{1'b1}} - idx_s;
        neg  = 1'b1;
      end
      default: begin
        addr = idx_s;
        neg  = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/sin_table_seq.sv
// Quarter-wave DDS sequencer: phase accumulator -> sin ROM read -> signed sample stream.
// Build option: SIN_SEQ_COS_EN adds a second (cos) read per sample and cos_data.
module sin_table_seq
  import sin_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADR_WIDTH   = 8,
  parameter int PHASE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   phase_clr,
  input  logic [PHASE_WIDTH-1:0] phase_inc,
  sin_table_seq_if.master        bus
);
  localparam logic [PHASE_WIDTH-1:0] QSTEP = PHASE_WIDTH'(quarter_step(PHASE_WIDTH));

  seq_state_e             state_r, state_nxt_s;
  logic [PHASE_WIDTH-1:0] phase_r, phase_nxt_s;
  logic [ADR_WIDTH-1:0]   sin_addr_s, tbl_addr_r;
  logic                   sin_neg_s, sin_neg_r;
  logic                   tbl_rd_r, rd_s, out_valid_r;
  logic [DATA_WIDTH:0]    mag_s, out_data_r;

  function automatic logic [DATA_WIDTH:0] apply_sign(input logic [DATA_WIDTH:0] m, input logic neg);
    return neg ? ({(DATA_WIDTH+1){1'b0}} - m) : m;
  endfunction

  assign mag_s = {1'b0, bus.tbl_dout};

  sin_quadrant_fold #(.PHASE_WIDTH(PHASE_WIDTH), .ADR_WIDTH(ADR_WIDTH)) u_fold_sin (
    .phase (phase_nxt_s),
    .addr  (sin_addr_s),
    .neg   (sin_neg_s)
  );

`ifdef SIN_SEQ_COS_EN
  logic [PHASE_WIDTH-1:0] cos_phase_s;
  logic [ADR_WIDTH-1:0]   cos_addr_s;
  logic                   cos_neg_s, cos_neg_r;
  logic [DATA_WIDTH:0]    cos_data_r;

  assign cos_phase_s = phase_nxt_s + QSTEP;

  sin_quadrant_fold #(.PHASE_WIDTH(PHASE_WIDTH), .ADR_WIDTH(ADR_WIDTH)) u_fold_cos (
    .phase (cos_phase_s),
    .addr  (cos_addr_s),
    .neg   (cos_neg_s)
  );

  assign rd_s         = (state_nxt_s == ST_RD) || (state_nxt_s == ST_RDC);
  assign bus.cos_data = cos_data_r;
`else
  assign rd_s = (state_nxt_s == ST_RD);
`endif

  // Next state and next phase; phase_clr overrides everything including a handshake.
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_r;
    if (phase_clr) begin
      state_nxt_s = ST_IDLE;
      phase_nxt_s = {PHASE_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (en) begin
            state_nxt_s = ST_RD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RD: state_nxt_s = ST_CAP;
`ifdef SIN_SEQ_COS_EN
        ST_CAP:  state_nxt_s = ST_RDC;
        ST_RDC:  state_nxt_s = ST_CAPC;
        ST_CAPC: state_nxt_s = ST_OUT;
`else
        ST_CAP:  state_nxt_s = ST_OUT;
`endif
        ST_OUT: begin
          if (bus.out_ready) begin
            phase_nxt_s = phase_r + phase_inc;
            state_nxt_s = en ? ST_RD : ST_IDLE;
          end else begin
            state_nxt_s = ST_OUT;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State and phase accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      phase_r <= {PHASE_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  // ROM request: strobe for one cycle on entry to a read state, address held in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_rd_r   <= 1'b0;
      tbl_addr_r <= {ADR_WIDTH{1'b0}};
      sin_neg_r  <= 1'b0;
`ifdef SIN_SEQ_COS_EN
      cos_neg_r  <= 1'b0;
`endif
    end else begin
      tbl_rd_r <= rd_s;
      if (state_nxt_s == ST_RD) begin
        tbl_addr_r <= sin_addr_s;
        sin_neg_r  <= sin_neg_s;
      end
`ifdef SIN_SEQ_COS_EN
      if (state_nxt_s == ST_RDC) begin
        tbl_addr_r <= cos_addr_s;
        cos_neg_r  <= cos_neg_s;
      end
`endif
    end
  end

  // Sample capture one cycle after each read, and the output valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(DATA_WIDTH+1){1'b0}};
`ifdef SIN_SEQ_COS_EN
      cos_data_r  <= {(DATA_WIDTH+1){1'b0}};
`endif
    end else begin
      out_valid_r <= (state_nxt_s == ST_OUT);
      if ((state_r == ST_CAP) && !phase_clr) begin
        out_data_r <= apply_sign(mag_s, sin_neg_r);
      end
`ifdef SIN_SEQ_COS_EN
      if ((state_r == ST_CAPC) && !phase_clr) begin
        cos_data_r <= apply_sign(mag_s, cos_neg_r);
      end
`endif
    end
  end

  assign bus.tbl_rd    = tbl_rd_r;
  assign bus.tbl_addr  = tbl_addr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
endmodule

// File: tb/tb_sin_table_seq.sv
// Self-checking bench for sin_table_seq: directed vector table, corner sequences, random run vs model.
// Define SIN_SEQ_COS_EN to exercise the cos build.
module tb_sin_table_seq;
`ifdef SIN_SEQ_COS_EN
  localparam bit COS = 1'b1;
  localparam int LAT = 5;
`else
  localparam bit COS = 1'b0;
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        phase_clr = 1'b0;
  logic [15:0] phase_inc = 16'h0000;

  sin_table_seq_if #(.DATA_WIDTH(8), .ADR_WIDTH(8)) bus ();

  sin_table_seq #(.DATA_WIDTH(8), .ADR_WIDTH(8), .PHASE_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .phase_clr (phase_clr),
    .phase_inc (phase_inc),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int ram [256];
  int checks = 0;
  int passed = 0;
  int hs_count = 0;

  // ROM model with one cycle of registered read latency
  always @(posedge clk) begin
    if (bus.tbl_rd) bus.tbl_dout <= 8'(ram[bus.tbl_addr]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_addr(input logic [15:0] ph);
    int p = int'(ph);
    int q = p / 16384;
    int idx = (p % 16384) / 64;
    if (q % 2 == 1) idx = 255 - idx;
    return idx[7:0];
  endfunction

  function automatic logic [8:0] exp_sample(input logic [15:0] ph);
    int v = ram[exp_addr(ph)];
    if (int'(ph) / 16384 >= 2) v = -v;
    return v[8:0];
  endfunction

  // Reference phase: advances on handshakes, cleared by phase_clr or reset
  logic [15:0] model_phase;
  logic        rd_cos;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_phase <= 16'h0000;
      rd_cos      <= 1'b0;
    end else if (phase_clr) begin
      model_phase <= 16'h0000;
      rd_cos      <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) model_phase <= model_phase + phase_inc;
      if (bus.tbl_rd) rd_cos <= COS ? ~rd_cos : 1'b0;
    end
  end

  logic       prev_rd = 1'b0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_data = 9'h000;
  logic [7:0] prev_addr = 8'h00;

  // Continuous monitor: addresses, samples, strobe width and backpressure stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (bus.tbl_rd) begin
        check("rd_addr", 32'(bus.tbl_addr),
              32'((COS && rd_cos) ? exp_addr(model_phase + 16'h4000) : exp_addr(model_phase)));
        check("rd_single_cycle", 32'(prev_rd), 32'd0);
      end
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'(bus.out_data), 32'(prev_data));
        check("stall_rd", 32'(bus.tbl_rd), 32'd0);
        check("stall_addr", 32'(bus.tbl_addr), 32'(prev_addr));
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_count++;
        check("sin_sample", 32'(bus.out_data), 32'(exp_sample(model_phase)));
`ifdef SIN_SEQ_COS_EN
        check("cos_sample", 32'(bus.cos_data), 32'(exp_sample(model_phase + 16'h4000)));
`endif
      end
      prev_rd    = bus.tbl_rd;
      prev_stall = bus.out_valid && !bus.out_ready && !phase_clr;
      prev_data  = bus.out_data;
      prev_addr  = bus.tbl_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.tbl_rd && n < 40);
    check("wait_rd", 32'(bus.tbl_rd), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.out_valid && n < 40);
    check("wait_valid", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic clr_pulse();
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
  endtask

  typedef struct {
    logic [15:0] inc;
    logic [7:0]  addr;
    logic [8:0]  data;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] d;
    logic [7:0] a;
    int         lat;

    for (int i = 0; i < 256; i++)
      ram[i] = int'($floor(255.0 * $sin(3.14159265358979 * real'(i) / 510.0) + 0.5));

    vecs[0] = '{16'h4000, 8'd0,   9'h000};
    vecs[1] = '{16'h4000, 8'd255, 9'h0FF};
    vecs[2] = '{16'h4000, 8'd0,   9'h000};
    vecs[3] = '{16'h4000, 8'd255, 9'h101};
    for (int i = 0; i < 4; i++) vecs[4+i] = '{16'h0040, 8'(i), 9'(ram[i])};

    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_tbl_rd", 32'(bus.tbl_rd), 32'd0);
    check("rst_tbl_addr", 32'(bus.tbl_addr), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || vecs[i].inc != vecs[i-1].inc) begin
        en = 1'b0;
        phase_inc = vecs[i].inc;
        clr_pulse();
        en = 1'b1;
      end
      wait_rd();
      check("vec_addr", 32'(bus.tbl_addr), 32'(vecs[i].addr));
      wait_valid();
      check("vec_data", 32'(bus.out_data), 32'(vecs[i].data));
    end

    // Latency from en in IDLE to out_valid
    en = 1'b0;
    clr_pulse();
    tick();
    en = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.out_valid && lat < 20);
    check("latency", 32'(lat), 32'(LAT));

    // Backpressure: hold out_ready low for 5 cycles in OUT
    phase_inc = 16'h0040;
    bus.out_ready = 1'b0;
    wait_valid();
    d = bus.out_data;
    a = bus.tbl_addr;
    repeat (5) begin
      tick();
      check("bp_data", 32'(bus.out_data), 32'(d));
      check("bp_rd", 32'(bus.tbl_rd), 32'd0);
      check("bp_addr", 32'(bus.tbl_addr), 32'(a));
    end
    bus.out_ready = 1'b1;
    wait_rd();
    check("bp_next_addr", 32'(bus.tbl_addr), 32'(exp_addr(model_phase)));

    // phase_clr while capturing aborts the sample
    en = 1'b0;
    clr_pulse();
    en = 1'b1;
    phase_inc = 16'h1234;
    wait_rd();
    tick();
    phase_clr = 1'b1;
    en = 1'b0;
    tick();
    phase_clr = 1'b0;
    check("clr_tbl_rd", 32'(bus.tbl_rd), 32'd0);
    repeat (4) begin
      check("clr_valid", 32'(bus.out_valid), 32'd0);
      tick();
    end
    en = 1'b1;
    wait_rd();
    check("clr_next_addr", 32'(bus.tbl_addr), 32'd0);

    // Randomized run against the model
    for (int c = 0; c < 500; c++) begin
      phase_inc     = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      en            = ($urandom_range(0, 9) != 0);
      phase_clr     = ($urandom_range(0, 49) == 0);
      tick();
    end
    phase_clr = 1'b0;
    check("random_handshakes_seen", 32'(hs_count > 20), 32'd1);

    // Asynchronous reset mid-run
    en = 1'b1;
    bus.out_ready = 1'b1;
    phase_inc = 16'h0567;
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_tbl_rd", 32'(bus.tbl_rd), 32'd0);
    check("arst_tbl_addr", 32'(bus.tbl_addr), 32'd0);
    check("arst_out_data", 32'(bus.out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_rd();
    check("arst_first_addr", 32'(bus.tbl_addr), 32'd0);
    wait_valid();
    check("arst_first_data", 32'(bus.out_data), 32'(9'(ram[0])));
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
